// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// FSM state encoding, default port widths and wait-counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int WAIT_CNT_W     = 4;

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module saturating_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  input  logic [WAIT_CNT_W-1:0] limit,
  output logic [WAIT_CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for one shared memory port. Data wins ties
// until fetch has lost MAX_IF_WAIT consecutive contested grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MAX_IF_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_IF_WAIT);

  arb_state_t             state, next_state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   we_q;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   if_elig, d_elig, wait_sat;
  logic                   grant_if, grant_d;

  // A requester whose done is high this cycle is being retired, not re-served.
  assign if_elig  = if_req & ~if_done;
  assign d_elig   = d_req & ~d_done;
  assign wait_sat = (wait_cnt == WAIT_LIMIT);
  assign stall    = (if_req & ~if_done) | (d_req & ~d_done);

  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!d_elig || wait_sat)) begin
          grant_if   = 1'b1;
          next_state = SERVE_IF;
        end else if (d_elig) begin
          grant_d    = 1'b1;
          next_state = SERVE_D;
        end
      end
      SERVE_IF: if (mem_ready) next_state = IDLE;
      SERVE_D:  if (mem_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  saturating_counter u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d & if_req),
    .clr   (grant_if),
    .limit (WAIT_LIMIT),
    .count (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      state   <= next_state;
      if_done <= (state == SERVE_IF) && mem_ready;
      d_done  <= (state == SERVE_D) && mem_ready;
      if (grant_if) begin
        addr_q <= if_addr;
        we_q   <= 1'b0;
      end
      if (grant_d) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
      end
      if ((state == SERVE_IF) && mem_ready) if_rdata <= mem_rdata;
      if ((state == SERVE_D) && mem_ready && !we_q) d_rdata <= mem_rdata;
    end
  end

  // Memory-side outputs depend only on registered state, never on mem_ready.
  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == SERVE_D) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation limit,
// wait states, reset abort and spurious ready.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_addr;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 0;
    step(); step();
    reset = 1'b0; #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    // Single fetch: cycle 0 request, ready on cycle 2, done on cycle 3
    step();
    if_req = 1; if_addr = 32'h0040_0010; #1;
    chk("f_c0_stall", {31'b0, stall}, 32'd1);
    chk("f_c0_mem_req", {31'b0, mem_req}, 32'd0);
    step(); #1;
    chk("f_c1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("f_c1_mem_addr", mem_addr, 32'h0040_0010);
    chk("f_c1_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    mem_ready = 1; mem_rdata = 32'h8C09_0004; #1;
    chk("f_c2_mem_req", {31'b0, mem_req}, 32'd1);
    chk("f_c2_done", {31'b0, if_done}, 32'd0);
    step();
    mem_ready = 0; mem_rdata = 32'h0; #1;
    chk("f_c3_if_done", {31'b0, if_done}, 32'd1);
    chk("f_c3_mem_req", {31'b0, mem_req}, 32'd0);
    chk("f_c3_if_rdata", if_rdata, 32'h8C09_0004);
    chk("f_c3_stall", {31'b0, stall}, 32'd0);
    if_req = 0;
    step(); #1;
    chk("f_c4_if_done", {31'b0, if_done}, 32'd0);
    chk("f_c4_rdata_hold", if_rdata, 32'h8C09_0004);
    chk("f_c4_mem_addr_hold", mem_addr, 32'h0040_0010);

    // Simultaneous: data write first, fetch granted in the d_done cycle
    step();
    if_req = 1; if_addr = 32'h0040_0020;
    d_req = 1; d_we = 1; d_addr = 32'h1001_0000; d_wdata = 32'hA5A5_A5A5;
    step(); #1;
    chk("s_d_mem_addr", mem_addr, 32'h1001_0000);
    chk("s_d_mem_we", {31'b0, mem_we}, 32'd1);
    chk("s_d_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("s_cnt_after_d", {28'b0, dut.wait_cnt}, 32'd1);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 0; d_req = 0; d_we = 0; #1;
    chk("s_d_done", {31'b0, d_done}, 32'd1);
    chk("s_d_done_mem_req", {31'b0, mem_req}, 32'd0);
    chk("s_d_rdata_unch", d_rdata, 32'd0);
    step(); #1;
    chk("s_if_mem_req", {31'b0, mem_req}, 32'd1);
    chk("s_if_mem_addr", mem_addr, 32'h0040_0020);
    chk("s_if_mem_we", {31'b0, mem_we}, 32'd0);
    chk("s_d_done_pulse", {31'b0, d_done}, 32'd0);
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    step();
    mem_ready = 0; if_req = 0; #1;
    chk("s_if_done", {31'b0, if_done}, 32'd1);
    chk("s_if_rdata", if_rdata, 32'h1111_2222);
    chk("s_cnt_cleared", {28'b0, dut.wait_cnt}, 32'd0);
    chk("s_d_rdata_final", d_rdata, 32'd0);

    // Starvation: fetch contends in every idle cycle, loses MAX_IF_WAIT times
    if_addr = 32'h0040_0030;
    for (int k = 0; k < 4; k++) begin
      step();
      if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h1001_0000 + 32'(k * 4);
      step(); #1;
      chk("v_d_grant_addr", mem_addr, 32'h1001_0000 + 32'(k * 4));
      chk("v_d_grant_we", {31'b0, mem_we}, 32'd0);
      mem_ready = 1; mem_rdata = 32'h100 + 32'(k);
      step();
      mem_ready = 0; if_req = 0; d_req = 0; #1;
      chk("v_d_done", {31'b0, d_done}, 32'd1);
      chk("v_d_rdata", d_rdata, 32'h100 + 32'(k));
      chk("v_cnt", {28'b0, dut.wait_cnt}, 32'(k + 1));
    end
    step();
    if_req = 1; d_req = 1; d_addr = 32'h1001_0100;
    step(); #1;
    chk("v_fetch_grant", mem_addr, 32'h0040_0030);
    chk("v_fetch_we", {31'b0, mem_we}, 32'd0);
    chk("v_cnt_zero", {28'b0, dut.wait_cnt}, 32'd0);
    mem_ready = 1; mem_rdata = 32'h0000_0077;
    step();
    mem_ready = 0; if_req = 0; #1;
    chk("v_if_done", {31'b0, if_done}, 32'd1);
    chk("v_if_rdata", if_rdata, 32'h0000_0077);
    step(); #1;
    chk("b2b_d_mem_req", {31'b0, mem_req}, 32'd1);
    chk("b2b_d_addr", mem_addr, 32'h1001_0100);
    chk("b2b_cnt", {28'b0, dut.wait_cnt}, 32'd0);
    mem_ready = 1; mem_rdata = 32'h0000_0099;
    step();
    mem_ready = 0; d_req = 0; #1;
    chk("b2b_d_done", {31'b0, d_done}, 32'd1);
    chk("b2b_d_rdata", d_rdata, 32'h0000_0099);

    // Wait states: five cycles of mem_ready low, ready on the sixth
    step();
    d_req = 1; d_we = 0; d_addr = 32'h1001_0040;
    for (int c = 0; c < 6; c++) begin
      step();
      mem_ready = (c == 5); mem_rdata = (c == 5) ? 32'hCAFE_F00D : 32'h0; #1;
      if (c == 0) held_addr = mem_addr;
      chk("w_mem_req", {31'b0, mem_req}, 32'd1);
      chk("w_mem_addr", mem_addr, 32'h1001_0040);
      chk("w_stall", {31'b0, stall}, 32'd1);
      chk("w_no_done", {31'b0, d_done}, 32'd0);
    end
    chk("w_addr_stable", mem_addr, held_addr);
    step();
    mem_ready = 0; d_req = 0; #1;
    chk("w_done", {31'b0, d_done}, 32'd1);
    chk("w_rdata", d_rdata, 32'hCAFE_F00D);
    step(); #1;
    chk("w_done_once", {31'b0, d_done}, 32'd0);

    // Reset during the second SERVE_D cycle abandons the read
    step();
    d_req = 1; d_we = 0; d_addr = 32'h1001_0080;
    step();
    step();
    reset = 1; d_req = 0; #1;
    chk("r_pre_mem_req", {31'b0, mem_req}, 32'd1);
    step();
    reset = 0; #1;
    chk("r_mem_req", {31'b0, mem_req}, 32'd0);
    chk("r_d_done", {31'b0, d_done}, 32'd0);
    chk("r_d_rdata", d_rdata, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    mem_ready = 1; mem_rdata = 32'h5555_5555;
    step(); #1;
    chk("r_late_ready_done", {31'b0, d_done}, 32'd0);
    chk("r_late_ready_rdata", d_rdata, 32'd0);
    chk("r_late_mem_req", {31'b0, mem_req}, 32'd0);

    // Spurious ready in IDLE with no requests
    step(); #1;
    chk("sp_if_done", {31'b0, if_done}, 32'd0);
    chk("sp_d_done", {31'b0, d_done}, 32'd0);
    chk("sp_mem_req", {31'b0, mem_req}, 32'd0);
    chk("sp_stall", {31'b0, stall}, 32'd0);
    chk("sp_if_rdata", if_rdata, 32'd0);
    mem_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data ports.
REQ-003 Parameter MAX_IF_WAIT, default 4: consecutive fetch losses before fetch gets priority (range 1..15).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: `clk  in  1`, rising-edge clock; `reset  in  1`, synchronous active-high reset.
REQ-005 Fetch requester ports SHALL be: `if_req  in  1`; `if_addr  in  ADDR_WIDTH`; `if_rdata  out  DATA_WIDTH`; `if_done  out  1`, a one-cycle completion pulse.
REQ-006 Data requester ports SHALL be: `d_req  in  1`; `d_we  in  1`; `d_addr  in  ADDR_WIDTH`; `d_wdata  in  DATA_WIDTH`; `d_rdata  out  DATA_WIDTH`; `d_done  out  1`, a one-cycle completion pulse.
REQ-007 Shared memory ports SHALL be: `mem_req  out  1`; `mem_we  out  1`; `mem_addr  out  ADDR_WIDTH`; `mem_wdata  out  DATA_WIDTH`; `mem_rdata  in  DATA_WIDTH`; `mem_ready  in  1`, the completion strobe.
REQ-008 `stall  out  1` SHALL signal a pipeline freeze: `(if_req & ~if_done) | (d_req & ~d_done)`, combinational.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SERVE_IF and SERVE_D.
REQ-010 In IDLE, a requester is eligible when its req=1 and its done=0 in that same cycle.
REQ-011 In IDLE with exactly one requester eligible, the block SHALL grant it: latch addr, we and wdata into registers, then move to SERVE_IF or SERVE_D at the next edge.
REQ-012 In IDLE with both requesters eligible, the block SHALL grant data, unless the wait counter equals MAX_IF_WAIT, in which case it SHALL grant fetch.
REQ-013 The wait counter SHALL increment, saturating at MAX_IF_WAIT, on each data grant made while if_req=1; it SHALL clear on every fetch grant.
REQ-014 In SERVE_x, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL come from the latched registers. mem_we SHALL be 0 for fetch.
REQ-015 In SERVE_x with mem_ready=1 at an edge, the block SHALL load mem_rdata into x_rdata (reads only), assert x_done for the next cycle only, and return to IDLE. mem_req SHALL be 0 in that next cycle.
REQ-016 A data write completion SHALL leave d_rdata unchanged.
REQ-017 Latency: with a request first seen in IDLE at cycle N, mem_req SHALL be 1 from cycle N+1. If mem_ready=1 at cycle M, done SHALL be 1 at M+1. The minimum request-to-done latency is 2 cycles.
REQ-018 mem_ready while in IDLE SHALL be ignored.
REQ-019 If a requester drops req before its done, the block SHALL still complete the memory transaction and pulse done; no abort exists.
REQ-020 Outside the SERVE states, mem_addr/mem_wdata SHALL hold their last values and mem_req=mem_we=0.
REQ-021 if_rdata/d_rdata SHALL hold their value until the next read completion for that requester.
REQ-022 Back-to-back operation: a new eligible request in the done cycle of the other requester SHALL be granted in that cycle, with no idle gap beyond the done cycle.

Reset
REQ-023 While reset=1 at an edge, the block SHALL enter IDLE, clear the wait counter, and clear the latched address, wdata, we, if_rdata and d_rdata to 0. if_done, d_done, mem_req and mem_we SHALL be 0.
REQ-024 A reset during SERVE_x SHALL abandon the transaction: no done pulse, and a later mem_ready is ignored.

Structure
REQ-025 State encoding (IDLE=2'd0, SERVE_IF=2'd1, SERVE_D=2'd2) and default widths SHALL reside in the shared processor package/include.
REQ-026 The saturating wait counter SHALL be a separate sub-module, saturating_counter (width 4, increment/clear/limit inputs).
REQ-027 The block SHALL be otherwise flat. It SHALL contain no combinational path from mem_ready to mem_req.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x00400010, mem_ready=1 on cycle 2, mem_rdata=0x8C090004 -> mem_req cycles 1-2, if_done cycle 3, if_rdata=0x8C090004, stall=0 from cycle 3.
REQ-029 Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xA5A5A5A5 -> data granted first with mem_we=1; fetch granted in the d_done cycle; d_rdata unchanged.
REQ-030 Starvation: if_req held, d_req re-asserted after every d_done, MAX_IF_WAIT=4 -> 4 data grants, then a fetch grant, then the counter reads 0.
REQ-031 Memory wait states: mem_ready low for 5 cycles -> mem_req and mem_addr stable for 6 cycles, stall=1 throughout, exactly one done pulse.
REQ-032 Reset mid-read: reset in cycle 2 of SERVE_D -> next cycle IDLE, mem_req=0, no d_done, d_rdata=0; mem_ready=1 afterwards has no effect.
REQ-033 Spurious mem_ready=1 in IDLE with no requests -> no done pulse, no state change.
